wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 24 ++
 rtl/wb_arbiter_rr_picker.sv | 33 +++
 rtl/wb_arbiter.sv | 107 ++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared FU definitions: writeback payload type, field widths and the default writeback port count.
package wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int ROB_IDX_W  = 6;
  localparam int IMMB_IDX_W = 4;
  localparam int PRD_IDX_W  = 7;
  localparam int NUM_WB_DEF = 2;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  robIdx;
    logic                  use_imm;
    logic [IMMB_IDX_W-1:0] immBIdx;
    logic                  iprd_wen;
    logic [PRD_IDX_W-1:0]  iprd_idx;
    logic [XLEN-1:0]       wb_data;
  } wbInfo_t;

  // A single-entry index still needs one bit to hold a value.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// rr_picker: finds the first set request at or after i_start, wrapping past N-1 to 0.
module rr_picker
  import wb_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_vld
);

  int pos;

  // Scan farthest offset first so the nearest hit is the one left standing.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    pos   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = (int'(i_start) + off) % N;
      if (i_req[pos]) begin
        o_idx = W'(pos);
        o_vld = 1'b1;
      end
    end
    if (o_vld) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NUM_FU result sources onto NUM_WB registered writeback slots.
// Optional same-cycle bypass of granted results is built only when WB_BYPASS_EN is defined.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int NUM_WB = NUM_WB_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FU-1:0]    i_fu_complete,
  input  wbInfo_t              i_fu_wbInfo [NUM_FU],
  output logic [NUM_FU-1:0]    o_fu_wb_stall,
  input  logic                 i_wb_block,
  output logic [NUM_WB-1:0]    o_wb_vld,
  output wbInfo_t              o_wb_info [NUM_WB],
  output logic [NUM_WB-1:0]    o_rf_wen,
  output logic [NUM_WB-1:0]    o_byp_vld,
  output logic [PRD_IDX_W-1:0] o_byp_idx [NUM_WB],
  output logic [XLEN-1:0]      o_byp_data [NUM_WB]
);

  localparam int IW = idx_w(NUM_FU);

  logic [IW-1:0]     r_rr_ptr;
  logic [NUM_WB-1:0] r_wb_vld;
  logic [NUM_WB-1:0] r_rf_wen;
  wbInfo_t           r_wb_info [NUM_WB];

  logic [NUM_FU-1:0] w_req [NUM_WB];
  logic [NUM_FU-1:0] w_gnt [NUM_WB];
  logic [IW-1:0]     w_idx [NUM_WB];
  logic [NUM_WB-1:0] w_vld;
  wbInfo_t           w_sel [NUM_WB];
  logic [NUM_FU-1:0] w_gnt_all;
  logic [IW-1:0]     w_rr_nxt;

  // Every picker starts at rr_ptr; masking earlier grants yields the next requester in ring order.
  for (genvar k = 0; k < NUM_WB; k++) begin : g_pick
    if (k == 0) begin : g_first
      assign w_req[k] = (rst || i_wb_block) ? '0 : i_fu_complete;
    end else begin : g_next
      assign w_req[k] = w_req[k-1] & ~w_gnt[k-1];
    end

    rr_picker #(.N(NUM_FU), .W(IW)) u_pick (
      .i_req   (w_req[k]),
      .i_start (r_rr_ptr),
      .o_gnt   (w_gnt[k]),
      .o_idx   (w_idx[k]),
      .o_vld   (w_vld[k])
    );

    assign w_sel[k] = i_fu_wbInfo[w_idx[k]];
  end

  always_comb begin
    w_gnt_all = '0;
    w_rr_nxt  = r_rr_ptr;
    for (int k = 0; k < NUM_WB; k++) begin
      w_gnt_all = w_gnt_all | w_gnt[k];
      if (w_vld[k]) w_rr_nxt = (w_idx[k] == IW'(NUM_FU - 1)) ? '0 : w_idx[k] + 1'b1;
    end
  end

  assign o_fu_wb_stall = rst ? '0 : (i_fu_complete & ~w_gnt_all);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wb_vld <= '0;
      r_rf_wen <= '0;
      for (int k = 0; k < NUM_WB; k++) r_wb_info[k] <= '0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
      for (int k = 0; k < NUM_WB; k++) begin
        r_wb_vld[k]  <= w_vld[k];
        r_rf_wen[k]  <= w_vld[k] & w_sel[k].iprd_wen;
        r_wb_info[k] <= w_vld[k] ? w_sel[k] : '0;
      end
    end
  end

  assign o_wb_vld  = r_wb_vld;
  assign o_rf_wen  = r_rf_wen;
  assign o_wb_info = r_wb_info;

`ifdef WB_BYPASS_EN
  always_comb begin
    o_byp_vld = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      o_byp_idx[k]  = w_sel[k].iprd_idx;
      o_byp_data[k] = w_sel[k].wb_data;
      o_byp_vld[k]  = w_vld[k] & w_sel[k].iprd_wen;
    end
  end
`else
  always_comb begin
    o_byp_vld = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      o_byp_idx[k]  = '0;
      o_byp_data[k] = '0;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter (NUM_FU=4, NUM_WB=2): directed vectors push expected writebacks, a monitor pops them.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           i_fu_complete;
  wbInfo_t              i_fu_wbInfo [4];
  logic [3:0]           o_fu_wb_stall;
  logic                 i_wb_block;
  logic [1:0]           o_wb_vld;
  wbInfo_t              o_wb_info [2];
  logic [1:0]           o_rf_wen;
  logic [1:0]           o_byp_vld;
  logic [PRD_IDX_W-1:0] o_byp_idx [2];
  logic [XLEN-1:0]      o_byp_data [2];

  wb_arbiter #(.NUM_FU(4), .NUM_WB(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_fu_complete (i_fu_complete),
    .i_fu_wbInfo   (i_fu_wbInfo),
    .o_fu_wb_stall (o_fu_wb_stall),
    .i_wb_block    (i_wb_block),
    .o_wb_vld      (o_wb_vld),
    .o_wb_info     (o_wb_info),
    .o_rf_wen      (o_rf_wen),
    .o_byp_vld     (o_byp_vld),
    .o_byp_idx     (o_byp_idx),
    .o_byp_data    (o_byp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]           vld;
    logic [1:0]           rfwen;
    logic [ROB_IDX_W-1:0] rob0;
    logic [ROB_IDX_W-1:0] rob1;
    logic [XLEN-1:0]      data0;
    logic [XLEN-1:0]      data1;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected writeback for grants to FU a (slot 0) and, if vld[1], FU b (slot 1).
  task automatic push(input logic [1:0] vld, input int a, input int b);
    exp_t x;
    x.vld      = vld;
    x.rob0     = i_fu_wbInfo[a].robIdx;
    x.data0    = i_fu_wbInfo[a].wb_data;
    x.rfwen[0] = i_fu_wbInfo[a].iprd_wen;
    x.rob1     = vld[1] ? i_fu_wbInfo[b].robIdx : '0;
    x.data1    = vld[1] ? i_fu_wbInfo[b].wb_data : '0;
    x.rfwen[1] = vld[1] & i_fu_wbInfo[b].iprd_wen;
    q.push_back(x);
  endtask

  task automatic step(input logic [3:0] c, input logic b);
    @(posedge clk);
    #1;
    i_fu_complete = c;
    i_wb_block    = b;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && o_wb_vld != 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_wb", 64'(o_wb_vld), 64'd0);
      end else begin
        e = q.pop_front();
        chk("wb_vld", 64'(o_wb_vld), 64'(e.vld));
        chk("rf_wen", 64'(o_rf_wen), 64'(e.rfwen));
        chk("slot0_rob", 64'(o_wb_info[0].robIdx), 64'(e.rob0));
        chk("slot0_data", 64'(o_wb_info[0].wb_data), 64'(e.data0));
        if (e.vld[1]) begin
          chk("slot1_rob", 64'(o_wb_info[1].robIdx), 64'(e.rob1));
          chk("slot1_data", 64'(o_wb_info[1].wb_data), 64'(e.data1));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      i_fu_wbInfo[i]          = '0;
      i_fu_wbInfo[i].robIdx   = ROB_IDX_W'(10 + i);
      i_fu_wbInfo[i].iprd_wen = 1'b1;
      i_fu_wbInfo[i].iprd_idx = PRD_IDX_W'(i + 1);
      i_fu_wbInfo[i].wb_data  = XLEN'(32'h1000 + i);
    end
    rst           = 1'b1;
    i_fu_complete = 4'b1111;
    i_wb_block    = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #2;
      chk("rst_stall", 64'(o_fu_wb_stall), 64'd0);
      chk("rst_vld", 64'(o_wb_vld), 64'd0);
      chk("rst_rf_wen", 64'(o_rf_wen), 64'd0);
    end
    chk("rst_info0", 64'(o_wb_info[0].robIdx), 64'd0);
    chk("rst_info1", 64'(o_wb_info[1].wb_data), 64'd0);

    // Oversubscription: first grant cycle right after reset release.
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rr_after_rst", 64'(dut.r_rr_ptr), 64'd0);
    chk("over0_stall", 64'(o_fu_wb_stall), 64'b1100);
    push(2'b11, 0, 1);

    step(4'b1111, 1'b0);
    chk("over1_rr", 64'(dut.r_rr_ptr), 64'd2);
    chk("over1_stall", 64'(o_fu_wb_stall), 64'b0011);
    push(2'b11, 2, 3);

    step(4'b0000, 1'b0);
    chk("idle_rr", 64'(dut.r_rr_ptr), 64'd0);
    chk("idle_stall", 64'(o_fu_wb_stall), 64'd0);

    // Single request moves rr_ptr to 3 for the wrap case.
    step(4'b0100, 1'b0);
    chk("idle_vld0", 64'(o_wb_vld), 64'd0);
    chk("single_stall", 64'(o_fu_wb_stall), 64'd0);
    push(2'b01, 2, 0);

    step(4'b1001, 1'b0);
    chk("wrap_rr_in", 64'(dut.r_rr_ptr), 64'd3);
    chk("wrap_stall", 64'(o_fu_wb_stall), 64'd0);
    push(2'b11, 3, 0);

    // Blocked for two cycles.
    step(4'b0010, 1'b1);
    chk("wrap_rr_out", 64'(dut.r_rr_ptr), 64'd1);
    chk("blk0_stall", 64'(o_fu_wb_stall), 64'b0010);
    step(4'b0010, 1'b1);
    chk("blk1_stall", 64'(o_fu_wb_stall), 64'b0010);
    chk("blk1_vld", 64'(o_wb_vld), 64'd0);
    chk("blk1_rr", 64'(dut.r_rr_ptr), 64'd1);
    step(4'b0010, 1'b0);
    chk("unblk_vld", 64'(o_wb_vld), 64'd0);
    chk("unblk_stall", 64'(o_fu_wb_stall), 64'd0);
    push(2'b01, 1, 0);

    // Result with no destination register still completes in the ROB.
    i_fu_wbInfo[3].robIdx   = ROB_IDX_W'(5);
    i_fu_wbInfo[3].iprd_wen = 1'b0;
    step(4'b1000, 1'b0);
    chk("unblk_rr", 64'(dut.r_rr_ptr), 64'd2);
    chk("nord_stall", 64'(o_fu_wb_stall), 64'd0);
    push(2'b01, 3, 0);

    i_fu_wbInfo[2].iprd_idx = PRD_IDX_W'(17);
    i_fu_wbInfo[2].wb_data  = XLEN'(32'hDEAD);
    step(4'b0100, 1'b0);
    chk("nord_rr", 64'(dut.r_rr_ptr), 64'd0);
`ifdef WB_BYPASS_EN
    chk("byp_vld", 64'(o_byp_vld), 64'b01);
    chk("byp_idx", 64'(o_byp_idx[0]), 64'd17);
    chk("byp_data", 64'(o_byp_data[0]), 64'hDEAD);
`else
    chk("byp_tied_vld", 64'(o_byp_vld), 64'd0);
    chk("byp_tied_data", 64'(o_byp_data[0]), 64'd0);
`endif
    push(2'b01, 2, 0);

    step(4'b0110, 1'b0);
    chk("mix_rr", 64'(dut.r_rr_ptr), 64'd3);
    chk("mix_stall", 64'(o_fu_wb_stall), 64'd0);
    push(2'b11, 1, 2);

    step(4'b0111, 1'b0);
    chk("three_rr", 64'(dut.r_rr_ptr), 64'd3);
    chk("three_stall", 64'(o_fu_wb_stall), 64'b0100);
    push(2'b11, 0, 1);

    step(4'b0100, 1'b0);
    chk("held_rr", 64'(dut.r_rr_ptr), 64'd2);
    chk("held_stall", 64'(o_fu_wb_stall), 64'd0);
    push(2'b01, 2, 0);

    step(4'b0000, 1'b0);
    chk("final_rr", 64'(dut.r_rr_ptr), 64'd3);
    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
